// File: rtl/comparator_search_ctrl.sv
// Purpose : binary-search initiator for a FourBitCo comparator; drives B (guess), reads Greater/Equal.
// Latency : one probe per clock, worst case WIDTH+1 probes; done pulses the cycle after the last probe.
// Backpr. : none; start is only accepted in IDLE, and start while busy/done is ignored.
//
// Ports:
//   clk, rst_n     rising-edge clock, synchronous active-low reset
//   start          begin a search (sampled in IDLE only)
//   greater/equal  comparator outputs for A vs. the registered guess
//   guess          registered probe value, wired to comparator B
//   busy/done      busy high while probing; done is a one-cycle pulse at the end
//   found/result   search outcome, held until the next start
//   probes         number of sampled probe cycles in the last search
//   err            protocol error flag (only ever set when CMP_PROTOCOL_CHECK_EN is defined)
//
// Build option: define CMP_PROTOCOL_CHECK_EN to flag greater&equal together, and
// not-found terminations, as comparator protocol errors.
module comparator_search_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             greater,
  input  logic             equal,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH:0]   probes,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Bounds carry one extra bit so lo can reach 2**WIDTH and the midpoint sum never wraps.
  localparam logic [WIDTH:0] ONE  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0] MAXV = {1'b0, {WIDTH{1'b1}}};

  state_t           state_q, state_d;
  logic [WIDTH:0]   lo_q, lo_d, hi_q, hi_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic             found_q, found_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH:0]   probes_q, probes_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   guess_ext;
  logic [WIDTH:0]   next_lo, next_hi, mid_sum;
  logic             underflow;

  assign guess_ext = {1'b0, guess_q};
  assign mid_sum   = next_lo + next_hi;

  // Candidate interval after this probe, assuming equal is not asserted.
  always_comb begin
    next_lo   = lo_q;
    next_hi   = hi_q;
    underflow = 1'b0;
    if (greater) begin
      next_lo = guess_ext + ONE;
    end else begin
      next_hi   = guess_ext - ONE;
      underflow = (guess_q == '0);
    end
  end

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    guess_d  = guess_q;
    found_d  = found_q;
    result_d = result_q;
    probes_d = probes_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_PROBE;
          lo_d     = '0;
          hi_d     = MAXV;
          guess_d  = MAXV[WIDTH:1];
          probes_d = '0;
          found_d  = 1'b0;
          result_d = '0;
          err_d    = 1'b0;
        end
      end

      S_PROBE: begin
        probes_d = probes_q + ONE;
`ifdef CMP_PROTOCOL_CHECK_EN
        if (greater && equal) begin
          // A comparator cannot be both greater and equal: abort as an error.
          err_d    = 1'b1;
          found_d  = 1'b0;
          result_d = '0;
          state_d  = S_DONE;
        end else
`endif
        if (equal) begin
          found_d  = 1'b1;
          result_d = guess_q;
          state_d  = S_DONE;
        end else if (underflow || (next_lo > next_hi)) begin
          found_d  = 1'b0;
          result_d = '0;
`ifdef CMP_PROTOCOL_CHECK_EN
          // A consistent comparator always produces equal before the interval empties.
          err_d    = 1'b1;
`endif
          state_d  = S_DONE;
        end else begin
          lo_d    = next_lo;
          hi_d    = next_hi;
          guess_d = mid_sum[WIDTH:1];
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      guess_q  <= '0;
      found_q  <= 1'b0;
      result_q <= '0;
      probes_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      guess_q  <= guess_d;
      found_q  <= found_d;
      result_q <= result_d;
      probes_q <= probes_d;
      err_q    <= err_d;
    end
  end

  assign guess  = guess_q;
  assign busy   = (state_q == S_PROBE);
  assign done   = (state_q == S_DONE);
  assign found  = found_q;
  assign result = result_q;
  assign probes = probes_q;
`ifdef CMP_PROTOCOL_CHECK_EN
  assign err    = err_q;
`else
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_comparator_search_ctrl.sv
// Purpose : directed check of comparator_search_ctrl against a behavioural comparator.
// Latency : n/a (testbench).
// Backpr. : n/a (testbench).
module tb_comparator_search_ctrl;

`ifdef CMP_PROTOCOL_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       greater, equal;
  logic [3:0] guess;
  logic       busy, done, found, err;
  logic [3:0] result;
  logic [4:0] probes;

  logic [3:0] a_val;
  int         mode;   // 0: real comparator, 1: force 0/0, 2: force 1/1

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  comparator_search_ctrl #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .greater (greater),
    .equal   (equal),
    .guess   (guess),
    .busy    (busy),
    .done    (done),
    .found   (found),
    .result  (result),
    .probes  (probes),
    .err     (err)
  );

  always_comb begin
    greater = 1'b0;
    equal   = 1'b0;
    case (mode)
      0: begin
        greater = (a_val > guess);
        equal   = (a_val == guess);
      end
      2: begin
        greater = 1'b1;
        equal   = 1'b1;
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // seq holds expected guesses, element i in bits [4*i +: 4].
  task automatic run_and_check(input string nm, input logic [3:0] a, input int md,
                               input bit repulse, input int n, input logic [23:0] seq,
                               input bit ef, input logic [3:0] er, input bit ee);
    int  c;
    int  idx;
    bit  got_done;
    @(negedge clk);
    a_val = a;
    mode  = md;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_clr_found"},  found,  0);
    chk({nm, "_clr_probes"}, probes, 0);
    c = 0;
    idx = 0;
    got_done = 1'b0;
    while (!got_done && c < 12) begin
      if (busy) begin
        if (idx < n) chk($sformatf("%s_g%0d", nm, idx), guess, seq[idx*4 +: 4]);
        idx++;
      end
      if (done) begin
        got_done = 1'b1;
      end else begin
        start = (repulse && c == 1);
        c++;
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!got_done) begin
      chk({nm, "_timeout"}, 0, 1);
    end else begin
      chk({nm, "_done_cyc"}, c,      n);
      chk({nm, "_nguess"},   idx,    n);
      chk({nm, "_found"},    found,  ef);
      chk({nm, "_result"},   result, er);
      chk({nm, "_probes"},   probes, n);
      chk({nm, "_err"},      err,    ee);
      @(negedge clk);
      chk({nm, "_done_pulse"}, done,   0);
      chk({nm, "_idle"},       busy,   0);
      chk({nm, "_hold_res"},   result, er);
    end
  endtask

  initial begin
    int dcount;
    rst_n = 1'b0;
    start = 1'b0;
    a_val = 4'd0;
    mode  = 0;
    repeat (2) @(negedge clk);
    chk("rst_guess",  guess,  0);
    chk("rst_busy",   busy,   0);
    chk("rst_done",   done,   0);
    chk("rst_found",  found,  0);
    chk("rst_result", result, 0);
    chk("rst_probes", probes, 0);
    chk("rst_err",    err,    0);
    rst_n = 1'b1;

    run_and_check("a9",   4'd9,  0, 1'b0, 3, 24'h0009B7, 1'b1, 4'd9,  1'b0);
    run_and_check("a0",   4'd0,  0, 1'b0, 4, 24'h000137, 1'b1, 4'd0,  1'b0);
    run_and_check("a15",  4'd15, 0, 1'b0, 5, 24'h0FEDB7, 1'b1, 4'd15, 1'b0);
    run_and_check("f00",  4'd0,  1, 1'b0, 4, 24'h000137, 1'b0, 4'd0,  PCHK);
    if (PCHK)
      run_and_check("f11", 4'd0, 2, 1'b0, 1, 24'h000007, 1'b0, 4'd0, 1'b1);
    else
      run_and_check("f11", 4'd0, 2, 1'b0, 1, 24'h000007, 1'b1, 4'd7, 1'b0);
    run_and_check("rep9", 4'd9,  0, 1'b1, 3, 24'h0009B7, 1'b1, 4'd9,  1'b0);

    // Abort with reset while the second probe is pending.
    @(negedge clk);
    a_val = 4'd15;
    mode  = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("ab_g1", guess, 11);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("ab_busy",   busy,   0);
    chk("ab_done",   done,   0);
    chk("ab_guess",  guess,  0);
    chk("ab_found",  found,  0);
    chk("ab_result", result, 0);
    chk("ab_probes", probes, 0);
    chk("ab_err",    err,    0);
    dcount = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("ab_no_done", dcount, 0);

    run_and_check("a5",   4'd5,  0, 1'b0, 3, 24'h000537, 1'b1, 4'd5,  1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
